bubble_sort_engine: RTL and testbench

- Self-contained, parametrised in-place sorter: owns a DEPTH×WIDTH register array and drives its own compare/swap datapath.
- Sorts ascending or descending, unsigned or signed, with early termination on the first pass that makes no swap.
- Sits behind a host load/readout port.
- Next-generation replacement for the fixed-size controller-plus-external-datapath sorter.

---
 rtl/bubble_sort_engine.sv | 111 +++++++++++
 tb/tb_bubble_sort_engine.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine: in-place bubble sorter with host load/readout port
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         begin a sort (IDLE/DONE only), 0 = ascending, 1 = descending
//   wr_en/addr/data     host write into the array (IDLE/DONE only)
//   rd_addr, rd_data    combinational readout of the array
//   busy, done          sort in progress / sort finished
//   cmp_count/swap_count saturating compare and swap counts of the last sort
module bubble_sort_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit SIGNED = 1'b0,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      cmp_count,
  output logic [15:0]      swap_count
);
  localparam int LAST = DEPTH - 2;
  typedef enum logic [2:0] {IDLE, LOAD, CMP, SWAP, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a, b;
  logic [AW-1:0] p, j, j1;
  logic mode_q, sw, gt, lt, ooo, adv, more, sw_eff;
  always_comb begin
    j1 = j + 1'b1;
    gt = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
    lt = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
    ooo = mode_q ? lt : gt;
    // ADVANCE happens on an in-order CMP or on any SWAP
    adv = (state == SWAP) || (state == CMP && !ooo);
    more = int'(j) + int'(p) < LAST;
    // a swap in this cycle counts towards the pass-swapped flag
    sw_eff = sw || (state == SWAP);
    rd_data = int'(rd_addr) < DEPTH ? mem[rd_addr] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      a <= '0;
      b <= '0;
      p <= '0;
      j <= '0;
      sw <= 1'b0;
      mode_q <= 1'b0;
      cmp_count <= '0;
      swap_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (wr_en && int'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
          if (start) begin
            mode_q <= mode;
            p <= '0;
            j <= '0;
            sw <= 1'b0;
            cmp_count <= '0;
            swap_count <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          a <= mem[j];
          b <= mem[j1];
          state <= CMP;
        end
        CMP: begin
          cmp_count <= cmp_count + 16'(cmp_count != 16'hFFFF);
          if (ooo) state <= SWAP;
        end
        SWAP: begin
          mem[j] <= b;
          mem[j1] <= a;
          sw <= 1'b1;
          swap_count <= swap_count + 16'(swap_count != 16'hFFFF);
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (more) begin
          j <= j1;
          state <= LOAD;
        end else if (!sw_eff || int'(p) == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          p <= p + 1'b1;
          j <= '0;
          sw <= 1'b0;
          state <= LOAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_bubble_sort_engine.sv
// tb_bubble_sort_engine: scoreboard bench for bubble_sort_engine across four configurations
module tb_bubble_sort_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, mode;
  logic [2:0] wa, ra;
  logic [7:0] wd;
  logic [3:0] start, we, busy, done;
  logic [7:0] rd [4];
  logic [15:0] cc [4];
  logic [15:0] sc [4];
  int errors = 0;
  int checks = 0;
  int sb[$];
  logic [7:0] m[$];
  int mc, ms;
  int dep [4] = '{8, 4, 4, 6};
  bit sgn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  bubble_sort_engine #(.WIDTH(8), .DEPTH(8), .SIGNED(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode), .wr_en(we[0]), .wr_addr(wa),
    .wr_data(wd), .rd_addr(ra), .rd_data(rd[0]), .busy(busy[0]), .done(done[0]),
    .cmp_count(cc[0]), .swap_count(sc[0]));
  bubble_sort_engine #(.WIDTH(8), .DEPTH(4), .SIGNED(1'b1)) u4s (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode), .wr_en(we[1]), .wr_addr(wa[1:0]),
    .wr_data(wd), .rd_addr(ra[1:0]), .rd_data(rd[1]), .busy(busy[1]), .done(done[1]),
    .cmp_count(cc[1]), .swap_count(sc[1]));
  bubble_sort_engine #(.WIDTH(8), .DEPTH(4), .SIGNED(1'b0)) u4u (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode), .wr_en(we[2]), .wr_addr(wa[1:0]),
    .wr_data(wd), .rd_addr(ra[1:0]), .rd_data(rd[2]), .busy(busy[2]), .done(done[2]),
    .cmp_count(cc[2]), .swap_count(sc[2]));
  bubble_sort_engine #(.WIDTH(8), .DEPTH(6), .SIGNED(1'b0)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode), .wr_en(we[3]), .wr_addr(wa),
    .wr_data(wd), .rd_addr(ra), .rd_data(rd[3]), .busy(busy[3]), .done(done[3]),
    .cmp_count(cc[3]), .swap_count(sc[3]));

  function automatic int val(logic [7:0] x, bit s);
    return s ? int'($signed(x)) : int'(x);
  endfunction

  // reference bubble sort with early exit; leaves sorted data in m, counts in mc/ms
  function automatic void model(bit desc, bit s);
    logic [7:0] t;
    bit swp;
    int x, y;
    mc = 0;
    ms = 0;
    for (int p = 0; p < m.size() - 1; p++) begin
      swp = 1'b0;
      for (int j = 0; j < m.size() - 1 - p; j++) begin
        x = val(m[j], s);
        y = val(m[j+1], s);
        mc++;
        if (desc ? x < y : x > y) begin
          t = m[j];
          m[j] = m[j+1];
          m[j+1] = t;
          ms++;
          swp = 1'b1;
        end
      end
      if (!swp) break;
    end
  endfunction

  task automatic do_sort(input int inst, input logic [7:0] d[$], input bit desc,
                         input bit load, input bit merge, input bit poke);
    int n, e;
    m = d;
    model(desc, sgn[inst]);
    foreach (m[i]) sb.push_back(int'(m[i]));
    sb.push_back(mc);
    sb.push_back(ms);
    sb.push_back(2 * mc + ms);
    if (load)
      for (int i = 0; i < d.size(); i++) begin
        @(negedge clk);
        we[inst] = 1'b1;
        wa = 3'(i);
        wd = d[i];
        if (merge && i == d.size() - 1) begin
          mode = desc;
          start[inst] = 1'b1;
        end
      end
    if (!(load && merge)) begin
      @(negedge clk);
      we[inst] = 1'b0;
      mode = desc;
      start[inst] = 1'b1;
    end
    @(negedge clk);
    we[inst] = 1'b0;
    start[inst] = 1'b0;
    checks++;
    if (busy[inst] !== 1'b1 || done[inst] !== 1'b0) begin
      errors++;
      $display("FAIL start_accept inst=%0d busy=%b done=%b, expected busy=1 done=0", inst, busy[inst], done[inst]);
    end
    n = 0;
    for (int k = 0; k < 4000 && done[inst] !== 1'b1; k++) begin
      if (busy[inst]) n++;
      if (poke && k == 10) begin
        we[inst] = 1'b1;
        wa = 3'd0;
        wd = 8'hAA;
        mode = !desc;
        start[inst] = 1'b1;
      end
      if (poke && k == 11) begin
        we[inst] = 1'b0;
        start[inst] = 1'b0;
        mode = desc;
      end
      @(negedge clk);
    end
    checks++;
    if (done[inst] !== 1'b1 || busy[inst] !== 1'b0) begin
      errors++;
      $display("FAIL finish inst=%0d done=%b busy=%b, expected done=1 busy=0", inst, done[inst], busy[inst]);
    end
    for (int i = 0; i < dep[inst]; i++) begin
      ra = 3'(i);
      #1;
      e = sb.pop_front();
      checks++;
      if (rd[inst] !== 8'(e)) begin
        errors++;
        $display("FAIL mem inst=%0d addr=%0d got %h expected %h", inst, i, rd[inst], 8'(e));
      end
    end
    e = sb.pop_front();
    checks++;
    if (cc[inst] !== 16'(e)) begin
      errors++;
      $display("FAIL cmp_count inst=%0d got %0d expected %0d", inst, cc[inst], e);
    end
    e = sb.pop_front();
    checks++;
    if (sc[inst] !== 16'(e)) begin
      errors++;
      $display("FAIL swap_count inst=%0d got %0d expected %0d", inst, sc[inst], e);
    end
    e = sb.pop_front();
    checks++;
    if (n !== e) begin
      errors++;
      $display("FAIL busy_cycles inst=%0d got %0d expected %0d", inst, n, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || cc[k] !== 16'd0 || sc[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset_status inst=%0d busy=%b done=%b cmp=%0d swap=%0d, expected all 0", k, busy[k], done[k], cc[k], sc[k]);
      end
      for (int i = 0; i < 8; i++) begin
        ra = 3'(i);
        #0.5;
        checks++;
        if (rd[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_mem inst=%0d addr=%0d got %h expected 00", k, i, rd[k]);
        end
      end
    end
  endtask

  task automatic test_sorted();
    logic [7:0] d[$];
    for (int i = 0; i < 8; i++) d.push_back(8'(i));
    do_sort(0, d, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reverse();
    logic [7:0] d[$];
    for (int i = 0; i < 8; i++) d.push_back(8'(7 - i));
    do_sort(0, d, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_descending();
    logic [7:0] d[$];
    logic [7:0] r[$];
    for (int i = 0; i < 8; i++) begin
      d.push_back(8'(i));
      r.push_back(8'(7 - i));
    end
    do_sort(0, d, 1'b1, 1'b1, 1'b0, 1'b0);
    do_sort(0, r, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_duplicates();
    logic [7:0] d[$];
    logic [7:0] e[$];
    for (int i = 0; i < 8; i++) begin
      d.push_back(8'd5);
      e.push_back(i % 2 ? 8'd1 : 8'd3);
    end
    do_sort(0, d, 1'b0, 1'b1, 1'b0, 1'b0);
    do_sort(0, e, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    logic [7:0] d[$];
    d.push_back(8'h7F);
    d.push_back(8'h80);
    d.push_back(8'hFF);
    d.push_back(8'h00);
    do_sort(1, d, 1'b0, 1'b1, 1'b0, 1'b0);
    do_sort(2, d, 1'b0, 1'b1, 1'b0, 1'b0);
    do_sort(1, d, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d[$];
    for (int i = 0; i < 8; i++) d.push_back(8'(7 - i));
    do_sort(0, d, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_write_with_start();
    logic [7:0] d[$];
    for (int i = 0; i < 8; i++) d.push_back(8'(i == 7 ? 0 : 200 - i));
    do_sort(0, d, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    for (int r = 0; r < 4; r++) begin
      d = {};
      for (int i = 0; i < 8; i++) d.push_back(8'(r[0] ? $urandom_range(0, 15) : $urandom_range(0, 255)));
      do_sort(0, d, r[1], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      we[0] = 1'b1;
      wa = 3'(i);
      wd = 8'(7 - i);
      @(negedge clk);
    end
    we[0] = 1'b0;
    mode = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || cc[0] !== 16'd0 || sc[0] !== 16'd0) begin
      errors++;
      $display("FAIL midsort_reset busy=%b done=%b cmp=%0d swap=%0d, expected all 0", busy[0], done[0], cc[0], sc[0]);
    end
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      #0.5;
      checks++;
      if (rd[0] !== 8'h00) begin
        errors++;
        $display("FAIL midsort_reset_mem addr=%0d got %h expected 00", i, rd[0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_out_of_range();
    logic [7:0] d[$];
    @(negedge clk);
    we[3] = 1'b1;
    wa = 3'd6;
    wd = 8'h55;
    @(negedge clk);
    wa = 3'd7;
    wd = 8'h66;
    @(negedge clk);
    wa = 3'd5;
    wd = 8'h77;
    @(negedge clk);
    we[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      #0.5;
      checks++;
      if (rd[3] !== (i == 5 ? 8'h77 : 8'h00)) begin
        errors++;
        $display("FAIL oor_access addr=%0d got %h expected %h", i, rd[3], i == 5 ? 8'h77 : 8'h00);
      end
    end
    for (int r = 0; r < 2; r++) begin
      d = {};
      for (int i = 0; i < 6; i++) d.push_back(8'($urandom_range(0, 255)));
      do_sort(3, d, r[0], 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    wa = '0;
    ra = '0;
    wd = '0;
    start = '0;
    we = '0;
    test_reset();
    test_sorted();
    test_reverse();
    test_descending();
    test_duplicates();
    test_signed();
    test_busy_ignore();
    test_write_with_start();
    test_random();
    test_reset_mid();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
